// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the memory access stage.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_BUS      = 2'b10,
    FC_TIMEOUT  = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  function automatic logic [7:0] size_mask(size_e s);
    logic [7:0] m;
    m = 8'h01;
    unique case (s)
      SIZE_B: m = 8'h01;
      SIZE_H: m = 8'h03;
      SIZE_W: m = 8'h0F;
      SIZE_D: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(logic [2:0] off, size_e s);
    logic bad;
    bad = 1'b0;
    unique case (s)
      SIZE_B: bad = 1'b0;
      SIZE_H: bad = off[0];
      SIZE_W: bad = |off[1:0];
      SIZE_D: bad = |off;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Right-aligns a load from its byte lane and zero/sign-extends it by size.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WORD_W = 64
) (
  input  logic [WORD_W-1:0] data_i,
  input  logic [2:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  output logic [WORD_W-1:0] data_o
);

  logic [WORD_W-1:0] sh;

  assign sh = data_i >> {off_i, 3'b000};

  always_comb begin
    data_o = sh;
    unique case (size_e'(size_i))
      SIZE_B: data_o = {{(WORD_W-8){sign_ext_i & sh[7]}}, sh[7:0]};
      SIZE_H: data_o = {{(WORD_W-16){sign_ext_i & sh[15]}}, sh[15:0]};
      SIZE_W: data_o = {{(WORD_W-32){sign_ext_i & sh[31]}}, sh[31:0]};
      SIZE_D: data_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: one load/store per request over a req/ack bus, with lane
// steering, byte enables, load extension and core stall control.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned WORD_W         = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [WORD_W-1:0] bus_addr,
  output logic [WORD_W-1:0] bus_wdata,
  output logic [7:0]        bus_wstrb,
  input  logic [WORD_W-1:0] bus_rdata,
  input  logic              bus_ack,
  input  logic              bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  fault_e              fcode_q, fcode_d;
  logic                capture;

  logic [WORD_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  size_e               size_q;
  logic                sext_q;
  logic                rd_q;
  logic                wr_q;

  logic [WORD_W-1:0]   ext_data;
  logic [2:0]          off;
  logic                in_req;

  assign off    = addr_q[2:0];
  assign in_req = (state_q == ST_REQ);

  mem_access_unit_load_extend #(
    .WORD_W (WORD_W)
  ) u_load_extend (
    .data_i     (bus_rdata),
    .off_i      (off),
    .size_i     (size_q),
    .sign_ext_i (sext_q),
    .data_o     (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fcode_d = fcode_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (mem_read && mem_write) begin
            state_d = ST_FAULT;
            fcode_d = FC_TIMEOUT;
          end else if (!mem_read && !mem_write) begin
            state_d = ST_DONE;
          end else if (misaligned(address[2:0], size_e'(size))) begin
            state_d = ST_FAULT;
            fcode_d = FC_MISALIGN;
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        // An ack in the final timeout cycle takes priority over the timeout.
        if (bus_ack) begin
          if (bus_err) begin
            state_d = ST_FAULT;
            fcode_d = FC_BUS;
          end else begin
            state_d = ST_DONE;
            if (rd_q) rdata_d = ext_data;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_d = ST_FAULT;
          fcode_d = FC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      fcode_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fcode_q <= fcode_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_B;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (capture) begin
      addr_q  <= address;
      wdata_q <= write_data;
      size_q  <= size_e'(size);
      sext_q  <= sign_ext;
      rd_q    <= mem_read;
      wr_q    <= mem_write;
    end
  end

  assign read_data  = rdata_q;
  assign fault_code = fcode_q;
  assign done       = (state_q == ST_DONE);
  assign fault      = (state_q == ST_FAULT);
  assign stall      = in_req | ((state_q == ST_IDLE) & start & (mem_read | mem_write));

  // Bus fields are forced to zero outside REQ so idle and reset look identical.
  assign bus_req   = in_req;
  assign bus_we    = in_req & wr_q;
  assign bus_addr  = in_req ? {addr_q[WORD_W-1:3], 3'b000} : '0;
  assign bus_wdata = in_req ? (wdata_q << {off, 3'b000}) : '0;
  assign bus_wstrb = in_req ? (size_mask(size_q) << off) : '0;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage that consumes the execute stage's ALU result as the effective address and register read data 2 as store data.
- Performs one LDUR/STUR-family access per request over a req/ack data bus.
- Does lane steering and byte enables, zero- or sign-extends loads, and holds the core stalled until the access completes or faults.
- Sits between execute and write-back in the non-pipelined core.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in REQ without ack before a timeout fault; 0 disables the timeout.
- WORD_W, `WORD (64), data and address width.

Ports:
- clk  input  1  core clock, all state on rising edge.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- start  input  1  request strobe; sampled only in IDLE.
- mem_read  input  1  load request.
- mem_write  input  1  store request.
- size  input  2  00 byte, 01 half, 10 word(32), 11 double.
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- address  input  WORD_W  effective address (ALU result).
- write_data  input  WORD_W  store data (read data 2), LSB-justified.
- read_data  output  WORD_W  extended load result.
- done  output  1  one-cycle completion pulse.
- fault  output  1  one-cycle fault pulse.
- fault_code  output  2  00 none, 01 misaligned, 10 bus error, 11 timeout/illegal.
- stall  output  1  core must hold PC and state.
- bus_req  output  1  bus request.
- bus_we  output  1  1 = write.
- bus_addr  output  WORD_W  address with bits[2:0] = 0.
- bus_wdata  output  WORD_W  lane-shifted store data.
- bus_wstrb  output  8  byte enables.
- bus_rdata  input  WORD_W  read data, valid when bus_ack = 1.
- bus_ack  input  1  access complete.
- bus_err  input  1  qualifies bus_ack as an error.

Behaviour:
- Reset (asynchronous, reset = 0):
  - state IDLE, timeout counter 0.
  - All outputs 0, including read_data, fault_code and bus fields.
  - bus_req deasserts immediately, even mid-access.
  - No done or fault pulse is produced for an access aborted by reset.
- States: IDLE, REQ, DONE, FAULT.
- IDLE with start = 1: capture all request inputs into registers, then decode:
  - mem_read & mem_write → FAULT, code 11.
  - Neither set → DONE; no bus cycle; read_data unchanged.
  - Misaligned → FAULT, code 01; no bus cycle. Misaligned means address[0] != 0 for half, address[1:0] != 0 for word, address[2:0] != 0 for double. Byte is never misaligned.
  - Otherwise → REQ.
- REQ:
  - bus_req = 1; bus_we, bus_addr, bus_wdata and bus_wstrb come from the captured registers and stay stable until exit.
  - Byte offset off = address[2:0].
  - bus_wstrb = size mask shifted left by off. Masks: byte 0x01, half 0x03, word 0x0F, double 0xFF.
  - bus_wdata = write_data << (8*off).
  - bus_ack & !bus_err → DONE. On a load, latch read_data = extend(bus_rdata >> 8*off, size, sign_ext) on this edge.
  - bus_ack & bus_err → FAULT, code 10.
  - Timeout (TIMEOUT_CYCLES > 0): counter increments each REQ cycle without ack. Reaching TIMEOUT_CYCLES-1 → FAULT, code 11. An ack in that same cycle wins over the timeout.
  - Counter clears on REQ entry.
- DONE: done = 1 for one cycle → IDLE.
- FAULT: fault = 1 for one cycle → IDLE.
- fault_code holds until the next fault or reset. read_data holds until the next load completes.
- stall = (state == REQ) | (state == IDLE & start & (mem_read | mem_write)). stall is 0 in DONE and FAULT, which lets the core advance on the pulse.
- start outside IDLE is ignored.
- Latency: with ack on the first REQ cycle, start at cycle N gives done at N+2. A no-op request gives done at N+1.

Decomposition:
- Shared package / constants.vh:
  - size encodings (SIZE_B/H/W/D).
  - fault codes.
  - state encoding localparams.
- Natural sub-module: load_extend (combinational shift-right by offset plus zero/sign extension by size). It is reused later by the write-back path.

Test Plan:
- Load double: address 0x1000, size 11, bus_rdata 0x8877665544332211 with ack on first REQ cycle → bus_addr 0x1000, wstrb 0xFF, we = 0, done at N+2, read_data 0x8877665544332211.
- Signed byte load: address 0x1003, size 00, sign_ext = 1, bus_rdata 0x00000000_80000000 → read_data 0xFFFFFFFFFFFFFF80. Repeat with sign_ext = 0 → 0x80.
- Half store: address 0x2006, size 01, write_data 0xBEEF → bus_addr 0x2000, wstrb 0xC0, wdata 0xBEEF000000000000, held stable through 3 wait cycles, then done.
- Misaligned word: address 0x3002, size 10 → no bus_req; fault pulse at N+1, fault_code 01.
- Timeout and error: TIMEOUT_CYCLES = 4 with no ack → fault after the 4th REQ cycle, code 11, bus_req drops. Separately, ack + err → fault code 10.
- Reset mid-access: reset = 0 during REQ → bus_req 0 immediately, no done/fault pulse. After release, a new request completes normally.
